s3g_rx: RTL and testbench
=========================

// Module: s3g_rx
// PURPOSE
//  Byte-level S3G packet receiver. Sits between the UART byte receiver and the command executor.
//  Hunts for the start byte, captures length and payload, then checks the trailing CRC8.
//  Presents the payload as a parallel 16-byte buffer with done/error strobes for the executor.
// PARAMETERS
//  MAX_PAYLOAD     16        payload bytes held in buf0..buf15; larger lengths are errors
//  START_BYTE      8'hD5     packet start marker
//  TIMEOUT_CYCLES  500000    inter-byte timeout in clk cycles (used only with S3G_RX_TIMEOUT_EN)
// PORTS
//  clk              in   1   system clock; all logic on rising edge
//  rst              in   1   reset, asynchronous, active-low (0 = reset)
//  rx_data          in   8   received UART byte
//  rx_data_valid    in   1   1-cycle strobe, rx_data valid; at most one byte per cycle
//  rx_packet_done   out  1   1-cycle pulse: good packet, buffer loaded
//  rx_packet_error  out  1   1-cycle pulse: bad length, bad CRC or timeout
//  rx_buffer_valid  out  1   level: buf*/payload_len hold the last good packet
//  rx_payload_len   out  8   payload length of the last good packet
//  rx_buf0..rx_buf15 out 8 each  payload bytes, byte 0 first
// BEHAVIOUR
//  Reset: state=S_IDLE; all outputs 0; idx, crc and timer 0. Reset mid-packet discards the packet.
//  FSM (advances only on rx_data_valid, except timeout):
//   S_IDLE:    byte==START_BYTE -> clear buf0..15, crc=0, buffer_valid=0, go S_LEN.
//              Any other byte is ignored.
//   S_LEN:     len>MAX_PAYLOAD -> error pulse, go S_IDLE. len==0 -> go S_CRC.
//              Otherwise latch len, idx=0, go S_PAYLOAD.
//   S_PAYLOAD: buf[idx]=byte; crc=crc8(crc,byte); idx++. When idx==len-1 -> S_CRC.
//              START_BYTE here is ordinary data.
//   S_CRC:     byte==crc -> done pulse, rx_payload_len=len, buffer_valid=1.
//              Otherwise error pulse, buffer_valid stays 0. Go S_IDLE either way.
//  CRC: Maxim/iButton CRC8, reflected polynomial 8'h8C, init 8'h00, over payload bytes only.
//   Processing is bitwise LSB-first: crc^=byte; 8x { crc = crc[0] ? (crc>>1)^8'h8C : crc>>1 }.
//  Latency: done or error is registered and asserts in the cycle after the deciding byte's
//   rx_data_valid. Buffer and length are stable from that cycle.
//  Buffer stability: buf/len are unchanged until the next START_BYTE is accepted in S_IDLE.
//   The executor reads them combinationally in the done cycle.
//  done and error are never asserted together; each is exactly 1 cycle.
//  Bytes arriving while the executor is busy are still parsed (no backpressure).
//   A new START_BYTE clears buffer_valid.
// CONFIGURATION
//  S3G_RX_TIMEOUT_EN defined:
//   - 32-bit timer runs in every state except S_IDLE.
//   - Timer resets on each rx_data_valid.
//   - Reaching TIMEOUT_CYCLES-1 -> error pulse, go S_IDLE, buffer_valid=0.
//  S3G_RX_TIMEOUT_EN undefined: no timer; a stalled packet waits indefinitely.
// STRUCTURE
//  Package s3g_pkg: START_BYTE, CRC8_POLY_REFL (8'h8C), MAX_PAYLOAD, state localparams.
//   The same package is shared with s3g_tx.
//  Sub-module crc8_maxim: combinational next-crc from (crc_in[7:0], data[7:0]).
//   Reused by s3g_tx.
//  Top level: FSM, idx counter, payload register file, timer.
// TESTING
//  1) Noise 00 FF 12, then D5 01 1B BD -> one done pulse, len=1, buf0=1B, buf1..15=00.
//  2) D5 01 1B BC -> one error pulse, no done, buffer_valid=0.
//  3) D5 00 00 -> done, len=0, buf0..15=00. D5 11 -> error right after length byte; FSM in S_IDLE.
//  4) D5 10, then 16 bytes 01..10 with correct CRC -> done, buf0=01 .. buf15=10.
//     Then D5 only -> buffer_valid drops.
//  5) rst low between payload bytes 2 and 3 -> all outputs 0.
//     Then D5 01 1B BD -> done.
//  6) S3G_RX_TIMEOUT_EN, TIMEOUT_CYCLES=100: D5 02 AA, idle 100 cycles -> error pulse.
//     Then D5 01 1B BD -> done.

Source files
------------

// File: rtl/s3g_pkg.sv
// Shared S3G protocol constants and types, used by the receiver and the transmitter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package s3g_pkg;

  localparam logic [7:0] START_BYTE     = 8'hD5;
  localparam logic [7:0] CRC8_POLY_REFL = 8'h8C;
  localparam int         MAX_PAYLOAD    = 16;

  // LEN_W holds 0..MAX_PAYLOAD inclusive; IDX_W addresses one payload slot.
  localparam int LEN_W = $clog2(MAX_PAYLOAD + 1);
  localparam int IDX_W = $clog2(MAX_PAYLOAD);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD,
    S_CRC
  } state_t;

  // Element [0] is payload byte 0.
  typedef logic [MAX_PAYLOAD-1:0][7:0] buf_t;

endpackage

// File: rtl/s3g_rx_if.sv
// Byte-in / packet-out bundle between the UART side, the S3G receiver and the executor.
// Latency: none (wires only).
// Backpressure: none; the byte stream cannot be stalled.
// Ports: rx_data/rx_data_valid (byte strobe in), rx_packet_done/rx_packet_error (1-cycle
//   strobes out), rx_buffer_valid (level), rx_payload_len, rx_buf (payload bytes, [0] first).
interface s3g_rx_if;
  import s3g_pkg::*;

  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       rx_packet_done;
  logic       rx_packet_error;
  logic       rx_buffer_valid;
  logic [7:0] rx_payload_len;
  buf_t       rx_buf;

  // master: byte source and result consumer; slave: the receiver itself.
  modport master (
    output rx_data, rx_data_valid,
    input  rx_packet_done, rx_packet_error, rx_buffer_valid, rx_payload_len, rx_buf
  );

  modport slave (
    input  rx_data, rx_data_valid,
    output rx_packet_done, rx_packet_error, rx_buffer_valid, rx_payload_len, rx_buf
  );

endinterface

// File: rtl/crc8_maxim.sv
// Maxim/iButton CRC8 (reflected poly 8'h8C) next-state for one byte, LSB-first.
// Latency: combinational.
// Backpressure: none.
// Ports: crc_in (running CRC), data (new byte), crc_out (updated CRC).
module crc8_maxim
  import s3g_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic [7:0] data,
  output logic [7:0] crc_out
);

  logic [7:0] c;

  always_comb begin
    c = crc_in ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC8_POLY_REFL) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/s3g_rx.sv
// S3G packet receiver: hunts START_BYTE, captures length and payload, checks trailing CRC8.
// Latency: done/error strobe registered, one cycle after the deciding byte's valid.
// Backpressure: none; every byte is parsed, a new START_BYTE drops the held buffer.
// Ports: clk, rst (async active-low), rx (s3g_rx_if.slave: byte stream in, packet results out).
// Optional macro S3G_RX_TIMEOUT_EN: inter-byte timeout of TIMEOUT_CYCLES clocks aborts a packet.
module s3g_rx
  import s3g_pkg::*;
`ifdef S3G_RX_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 500000
)
`endif
(
  input  logic    clk,
  input  logic    rst,
  s3g_rx_if.slave rx
);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       crc_q, crc_d, crc_next;
  buf_t             buf_q, buf_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             bv_q, bv_d;
  logic [7:0]       plen_q, plen_d;
  logic             timeout_hit;

  crc8_maxim u_crc (
    .crc_in  (crc_q),
    .data    (rx.rx_data),
    .crc_out (crc_next)
  );

`ifdef S3G_RX_TIMEOUT_EN
  logic [31:0] timer_q;

  // Timer idles at zero in S_IDLE and restarts on every accepted byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_q <= '0;
    end else if (state_q == S_IDLE || rx.rx_data_valid || timeout_hit) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + 32'd1;
    end
  end

  assign timeout_hit = (state_q != S_IDLE) && !rx.rx_data_valid &&
                       (timer_q == TIMEOUT_CYCLES - 1);
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    crc_d   = crc_q;
    buf_d   = buf_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    bv_d    = bv_q;
    plen_d  = plen_q;

    if (timeout_hit) begin
      err_d   = 1'b1;
      bv_d    = 1'b0;
      state_d = S_IDLE;
    end else if (rx.rx_data_valid) begin
      unique case (state_q)
        S_IDLE: begin
          if (rx.rx_data == START_BYTE) begin
            buf_d   = '0;
            crc_d   = '0;
            bv_d    = 1'b0;
            state_d = S_LEN;
          end
        end
        S_LEN: begin
          if (rx.rx_data > 8'(MAX_PAYLOAD)) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else if (rx.rx_data == 8'd0) begin
            // Empty packet: the CRC byte must equal the initial value.
            len_d   = '0;
            state_d = S_CRC;
          end else begin
            len_d   = rx.rx_data[LEN_W-1:0];
            idx_d   = '0;
            state_d = S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          buf_d[idx_q] = rx.rx_data;
          crc_d        = crc_next;
          idx_d        = idx_q + IDX_W'(1);
          // The slot just written is the last one; idx wraps harmlessly at len 16.
          if ({1'b0, idx_q} == len_q - LEN_W'(1)) begin
            state_d = S_CRC;
          end
        end
        S_CRC: begin
          if (rx.rx_data == crc_q) begin
            done_d = 1'b1;
            plen_d = 8'(len_q);
            bv_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      crc_q   <= '0;
      buf_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      bv_q    <= 1'b0;
      plen_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      crc_q   <= crc_d;
      buf_q   <= buf_d;
      done_q  <= done_d;
      err_q   <= err_d;
      bv_q    <= bv_d;
      plen_q  <= plen_d;
    end
  end

  assign rx.rx_packet_done  = done_q;
  assign rx.rx_packet_error = err_q;
  assign rx.rx_buffer_valid = bv_q;
  assign rx.rx_payload_len  = plen_q;
  assign rx.rx_buf          = buf_q;

endmodule

// File: tb/tb_s3g_rx.sv
// Self-checking bench for s3g_rx: directed vector table, mid-packet reset, stall/timeout,
// and randomized packets predicted from how each packet was built.
module tb_s3g_rx;
  import s3g_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  s3g_rx_if bus ();

`ifdef S3G_RX_TIMEOUT_EN
  s3g_rx #(.TIMEOUT_CYCLES(100)) dut (.clk(clk), .rst(rst), .rx(bus.slave));
`else
  s3g_rx dut (.clk(clk), .rst(rst), .rx(bus.slave));
`endif

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic [7:0] cap_len;
  buf_t cap_buf;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Pulse monitor, sampled on the falling edge away from register updates.
  always @(negedge clk) begin
    if (bus.rx_packet_done) begin
      done_cnt++;
      cap_len = bus.rx_payload_len;
      cap_buf = bus.rx_buf;
    end
    if (bus.rx_packet_error) err_cnt++;
    if (bus.rx_packet_done || bus.rx_packet_error)
      chk("done_error_exclusive", 128'(bus.rx_packet_done & bus.rx_packet_error), 128'd0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Reference CRC: Maxim CRC8 as defined on the byte sequence.
  function automatic logic [7:0] crc8_ref(input logic [7:0] d [16], input int n);
    logic [7:0] c = 8'h00;
    for (int i = 0; i < n; i++) begin
      c ^= d[i];
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 8'h8C) : (c >> 1);
    end
    return c;
  endfunction

  // Called at a falling edge; holds the byte for exactly one rising edge.
  task automatic send(input logic [7:0] b);
    bus.rx_data       = b;
    bus.rx_data_valid = 1'b1;
    @(negedge clk);
    bus.rx_data_valid = 1'b0;
    bus.rx_data       = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    string      name;
    logic [7:0] b [20];
    int         n;
    int         exp_done;
    int         exp_err;
    logic       exp_bv;
    logic [7:0] exp_len;
    buf_t       exp_buf;
  } vec_t;

  localparam int NV = 6;
  vec_t tbl [NV];

  task automatic load(input int k, input string name, input logic [159:0] pk, input int n,
                      input int d, input int e, input logic bv, input logic [7:0] len,
                      input buf_t eb);
    tbl[k].name = name;
    tbl[k].n    = n;
    for (int i = 0; i < 20; i++) tbl[k].b[i] = (i < n) ? pk[(n-1-i)*8 +: 8] : 8'h00;
    tbl[k].exp_done = d;
    tbl[k].exp_err  = e;
    tbl[k].exp_bv   = bv;
    tbl[k].exp_len  = len;
    tbl[k].exp_buf  = eb;
  endtask

  buf_t        eb;
  logic [7:0]  pay [16];
  logic [7:0]  c, nb;
  int          kind, n;

  initial begin
    bus.rx_data       = 8'h00;
    bus.rx_data_valid = 1'b0;

    // ---- vector table ----
    eb = '0; eb[0] = 8'h1B;
    load(0, "noise_good", {8'h00, 8'hFF, 8'h12, 8'hD5, 8'h01, 8'h1B, 8'hBD}, 7, 1, 0, 1'b1, 8'd1, eb);
    load(1, "bad_crc", {8'hD5, 8'h01, 8'h1B, 8'hBC}, 4, 0, 1, 1'b0, 8'd0, '0);
    load(2, "empty", {8'hD5, 8'h00, 8'h00}, 3, 1, 0, 1'b1, 8'd0, '0);
    load(3, "len17", {8'hD5, 8'h11}, 2, 0, 1, 1'b0, 8'd0, '0);
    for (int i = 0; i < 16; i++) begin
      pay[i] = 8'(i + 1);
      eb[i]  = 8'(i + 1);
    end
    tbl[4].name = "full16";
    tbl[4].n = 19;
    tbl[4].b[0] = 8'hD5;
    tbl[4].b[1] = 8'h10;
    for (int i = 0; i < 16; i++) tbl[4].b[2+i] = pay[i];
    tbl[4].b[18] = crc8_ref(pay, 16);
    tbl[4].b[19] = 8'h00;
    tbl[4].exp_done = 1; tbl[4].exp_err = 0; tbl[4].exp_bv = 1'b1;
    tbl[4].exp_len = 8'd16; tbl[4].exp_buf = eb;
    load(5, "start_only", {8'hD5}, 1, 0, 0, 1'b0, 8'd0, '0);

    // ---- reset state ----
    idle(3);
    chk("rst_done", 128'(bus.rx_packet_done), 128'd0);
    chk("rst_error", 128'(bus.rx_packet_error), 128'd0);
    chk("rst_bv", 128'(bus.rx_buffer_valid), 128'd0);
    chk("rst_len", 128'(bus.rx_payload_len), 128'd0);
    chk("rst_buf", 128'(bus.rx_buf), 128'd0);
    rst = 1'b1;
    idle(2);

    for (int k = 0; k < NV; k++) begin
      done_cnt = 0;
      err_cnt  = 0;
      for (int i = 0; i < tbl[k].n; i++) send(tbl[k].b[i]);
      idle(2);
      chk({tbl[k].name, "_done"}, 128'(done_cnt), 128'(tbl[k].exp_done));
      chk({tbl[k].name, "_error"}, 128'(err_cnt), 128'(tbl[k].exp_err));
      chk({tbl[k].name, "_bv"}, 128'(bus.rx_buffer_valid), 128'(tbl[k].exp_bv));
      if (tbl[k].exp_done != 0) begin
        chk({tbl[k].name, "_len"}, 128'(cap_len), 128'(tbl[k].exp_len));
        chk({tbl[k].name, "_buf"}, 128'(cap_buf), 128'(tbl[k].exp_buf));
      end
    end

    // ---- reset in the middle of a payload (len 16 still held from full16) ----
    send(8'hD5); send(8'h03); send(8'h11); send(8'h22);
    rst = 1'b0;
    idle(1);
    chk("midrst_done", 128'(bus.rx_packet_done), 128'd0);
    chk("midrst_error", 128'(bus.rx_packet_error), 128'd0);
    chk("midrst_bv", 128'(bus.rx_buffer_valid), 128'd0);
    chk("midrst_len", 128'(bus.rx_payload_len), 128'd0);
    chk("midrst_buf", 128'(bus.rx_buf), 128'd0);
    rst = 1'b1;
    idle(1);
    done_cnt = 0; err_cnt = 0;
    send(8'hD5); send(8'h01); send(8'h1B); send(8'hBD);
    idle(2);
    chk("postrst_done", 128'(done_cnt), 128'd1);
    chk("postrst_len", 128'(cap_len), 128'd1);
    chk("postrst_buf0", 128'(cap_buf[0]), 128'h1B);

    // ---- stalled packet ----
    done_cnt = 0; err_cnt = 0;
    send(8'hD5); send(8'h02); send(8'hAA);
`ifdef S3G_RX_TIMEOUT_EN
    idle(99);
    chk("timeout_early", 128'(err_cnt), 128'd0);
    idle(2);
    chk("timeout_error", 128'(err_cnt), 128'd1);
    chk("timeout_bv", 128'(bus.rx_buffer_valid), 128'd0);
    done_cnt = 0; err_cnt = 0;
    send(8'hD5); send(8'h01); send(8'h1B); send(8'hBD);
    idle(2);
    chk("after_timeout_done", 128'(done_cnt), 128'd1);
    chk("after_timeout_err", 128'(err_cnt), 128'd0);
`else
    idle(300);
    chk("stall_no_error", 128'(err_cnt), 128'd0);
    pay[0] = 8'hAA; pay[1] = 8'h5C;
    send(8'h5C); send(crc8_ref(pay, 2));
    idle(2);
    chk("stall_done", 128'(done_cnt), 128'd1);
    chk("stall_buf1", 128'(cap_buf[1]), 128'h5C);
`endif

    // ---- randomized packets, expectation from how each packet is built ----
    for (int p = 0; p < 40; p++) begin
      kind = $urandom_range(0, 2);
      n    = $urandom_range(0, 16);
      repeat ($urandom_range(0, 3)) begin
        do nb = 8'($urandom_range(0, 255)); while (nb == 8'hD5);
        send(nb);
        idle($urandom_range(0, 2));
      end
      done_cnt = 0; err_cnt = 0;
      eb = '0;
      send(8'hD5);
      idle($urandom_range(0, 2));
      if (kind == 2) begin
        send(8'($urandom_range(17, 255)));
      end else begin
        send(8'(n));
        for (int i = 0; i < n; i++) begin
          pay[i] = 8'($urandom_range(0, 255));
          eb[i]  = pay[i];
          idle($urandom_range(0, 2));
          send(pay[i]);
        end
        c = crc8_ref(pay, n);
        if (kind == 1) c ^= 8'($urandom_range(1, 255));
        idle($urandom_range(0, 2));
        send(c);
      end
      idle(2);
      chk($sformatf("rnd%0d_done", p), 128'(done_cnt), (kind == 0) ? 128'd1 : 128'd0);
      chk($sformatf("rnd%0d_error", p), 128'(err_cnt), (kind == 0) ? 128'd0 : 128'd1);
      chk($sformatf("rnd%0d_bv", p), 128'(bus.rx_buffer_valid), (kind == 0) ? 128'd1 : 128'd0);
      if (kind == 0) begin
        chk($sformatf("rnd%0d_len", p), 128'(cap_len), 128'(n));
        chk($sformatf("rnd%0d_buf", p), 128'(cap_buf), 128'(eb));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
